mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between two requesters of the 5-stage pipeline: the IF-stage instruction fetch port and the MEM-stage load/store port.
- Sequences each access through a fixed-latency memory and returns read data with a one-cycle valid pulse.
- Drives per-stage stall signals that the hazard logic ORs into the PC/IF_ID enables and the EX_MEM/MEM_WB hold.
- Data port has priority; a starvation counter guarantees forward progress on fetch.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_lat_counter.sv | 30 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and counter widths for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    localparam int unsigned LAT_W    = 3;
    localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing the memory read latency; done_c flags the final count.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned W = LAT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // Asserted in the cycle whose decrement brings the count to zero.
    assign done_c = dec && (count == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and the MEM load/store port onto one fixed-latency
// memory; data has priority, bounded by a starvation counter that forces a fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_req_rd,
    input  logic              d_req_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              err_proto
);

    state_t              state;
    state_t              state_nxt;
    owner_t              owner;
    logic                wr_q;
    logic [STARVE_W-1:0] starve;

    logic d_req_c;
    logic grant_data_c;
    logic grant_if_c;
    logic write_sel_c;
    logic lat_load_c;
    logic lat_dec_c;
    logic lat_done_c;
    logic resp_enter_c;

    assign d_req_c   = d_req_rd | d_req_wr;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = d_req_c & ~d_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (grant_data_c || grant_if_c) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = wr_q ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (lat_done_c) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant selection and per-state control strobes; grants only happen in IDLE.
    always_comb begin
        grant_data_c = 1'b0;
        grant_if_c   = 1'b0;
        if (state == ST_IDLE) begin
            if (d_req_c && (!if_req || (starve < STARVE_W'(STARVE_MAX)))) begin
                grant_data_c = 1'b1;
            end else if (if_req) begin
                grant_if_c = 1'b1;
            end
        end
        write_sel_c  = grant_data_c && d_req_wr;
        lat_load_c   = (state == ST_ISSUE) && !wr_q;
        lat_dec_c    = (state == ST_WAIT);
        resp_enter_c = ((state == ST_ISSUE) && wr_q) || lat_done_c;
    end

    mem_lat_counter #(
        .W(LAT_W)
    ) u_lat (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load_c),
        .load_val (LAT_W'(MEM_LATENCY)),
        .dec      (lat_dec_c),
        .done_c   (lat_done_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWN_NONE;
            wr_q      <= 1'b0;
            starve    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            err_proto <= 1'b0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            mem_re    <= (grant_data_c || grant_if_c) && !write_sel_c;
            mem_we    <= write_sel_c;
            err_proto <= grant_data_c && d_req_rd && d_req_wr;
            if_valid  <= resp_enter_c && (owner == OWN_IF);
            d_valid   <= resp_enter_c && (owner == OWN_DATA);

            if (grant_data_c) begin
                owner     <= OWN_DATA;
                wr_q      <= d_req_wr;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                // Counts data grants that overtook a waiting fetch.
                if (!if_req) begin
                    starve <= '0;
                end else if (starve < STARVE_W'(STARVE_MAX)) begin
                    starve <= starve + STARVE_W'(1);
                end
            end else if (grant_if_c) begin
                owner     <= OWN_IF;
                wr_q      <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                starve    <= '0;
            end

            if (lat_done_c) begin
                if (owner == OWN_IF) begin
                    if_rdata <= mem_rdata;
                end else if (owner == OWN_DATA) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two configurations, each with a memory, a
// transaction-timeline reference model, directed pins and random traffic.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          re_at, n_re, we_at, n_we, err_at, n_err, v_at;
        logic [31:0] data;
    } res_t;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Power-up contents of never-written memory words.
    function automatic logic [31:0] seed(input int a);
        if (a == 16) return 32'h8C22_0004;
        return 32'h5A00_0000 | (32'(a) * 32'h0001_0101);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int L  = (g == 0) ? 1 : 4;
        localparam int SM = (g == 0) ? 2 : 4;

        logic        rst, if_req, d_req_rd, d_req_wr;
        logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
        logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
        logic        if_valid, d_valid, mem_re, mem_we, stall_if, stall_mem, err_proto;
        bit          done = 1'b0;

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .STARVE_MAX(SM)
        ) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
            .d_req_rd(d_req_rd), .d_req_wr(d_req_wr), .d_addr(d_addr), .d_wdata(d_wdata),
            .d_rdata(d_rdata), .d_valid(d_valid),
            .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
            .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
            .err_proto(err_proto)
        );

        // Memory: data appears exactly L cycles after mem_re, noise otherwise.
        bit   [31:0] mem   [64];
        bit          mem_w [64];
        logic [31:0] rpipe [4];
        always @(posedge clk) begin
            if (mem_we) begin
                mem[mem_addr[5:0]]   <= mem_wdata;
                mem_w[mem_addr[5:0]] <= 1'b1;
            end
            rpipe[0] <= mem_re ? (mem_w[mem_addr[5:0]] ? mem[mem_addr[5:0]]
                                                        : seed(int'(mem_addr[5:0])))
                               : $urandom;
            for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
        end
        assign mem_rdata = rpipe[L-1];

        // Reference model: each grant schedules strobe and completion times.
        logic        x_re, x_we, x_err, x_ifv, x_dv, x_rst;
        logic [31:0] x_ifr, x_dr, x_addr, x_wd;
        bit   [31:0] sh   [64];
        bit          sh_w [64];

        initial begin : model
            int e, g_e, v_e, free_at, starve, a;
            bit busy, rd, own_if, perr;
            logic [31:0] rv;
            string p;
            p = $sformatf("cfg%0d ", g);
            e = 0; g_e = -1; v_e = -1; free_at = 0; starve = 0; a = 0;
            busy = 0; rd = 0; own_if = 0; perr = 0; rv = '0;
            x_ifr = '0; x_dr = '0; x_addr = '0; x_wd = '0;
            forever begin
                @(posedge clk);
                e++;
                x_re = 0; x_we = 0; x_err = 0; x_ifv = 0; x_dv = 0; x_rst = rst;
                if (rst) begin
                    busy = 0; free_at = e + 1; starve = 0;
                    x_ifr = '0; x_dr = '0; x_addr = '0;
                end else begin
                    if (!busy && e >= free_at) begin
                        if ((d_req_rd || d_req_wr) && (!if_req || starve < SM)) begin
                            busy = 1; own_if = 0; rd = !d_req_wr; perr = d_req_rd && d_req_wr;
                            x_addr = d_addr; x_wd = d_wdata;
                            starve = if_req ? ((starve < SM) ? starve + 1 : SM) : 0;
                        end else if (if_req) begin
                            busy = 1; own_if = 1; rd = 1; perr = 0;
                            x_addr = if_addr; starve = 0;
                        end
                        if (busy) begin
                            g_e = e;
                            v_e = rd ? e + 1 + L : e + 1;
                            a = int'(x_addr[5:0]);
                            if (rd) rv = sh_w[a] ? sh[a] : seed(a);
                            else begin sh[a] = x_wd; sh_w[a] = 1; end
                        end
                    end
                    if (busy && e == g_e) begin
                        x_re = rd; x_we = !rd; x_err = perr;
                    end
                    if (busy && e == v_e) begin
                        if (own_if) begin x_ifv = 1; if (rd) x_ifr = rv; end
                        else        begin x_dv  = 1; if (rd) x_dr  = rv; end
                        busy = 0; free_at = e + 2;
                    end
                end
                @(negedge clk);
                #1;
                chk({p, "mem_re"},    mem_re,    x_re);
                chk({p, "mem_we"},    mem_we,    x_we);
                chk({p, "err_proto"}, err_proto, x_err);
                chk({p, "if_valid"},  if_valid,  x_ifv);
                chk({p, "d_valid"},   d_valid,   x_dv);
                chk({p, "if_rdata"},  if_rdata,  x_ifr);
                chk({p, "d_rdata"},   d_rdata,   x_dr);
                chk({p, "mem_addr"},  mem_addr,  x_addr);
                chk({p, "stall_if"},  stall_if,  if_req && !x_ifv);
                chk({p, "stall_mem"}, stall_mem, (d_req_rd || d_req_wr) && !x_dv);
                if (x_we)  chk({p, "mem_wdata"}, mem_wdata, x_wd);
                if (x_rst) chk({p, "mem_wdata_rst"}, mem_wdata, 32'h0);
            end
        end

        // Raise one request now, follow it to completion, drop it after valid.
        task automatic run_req(input bit use_if, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] wd, output res_t r);
            r.re_at = -1; r.n_re = 0; r.we_at = -1; r.n_we = 0;
            r.err_at = -1; r.n_err = 0; r.v_at = -1; r.data = '0;
            if (use_if) begin
                if_req = 1; if_addr = addr;
            end else begin
                d_req_rd = rd; d_req_wr = wr; d_addr = addr; d_wdata = wd;
            end
            for (int c = 0; c < 40 && r.v_at < 0; c++) begin
                #1;
                if (mem_re)    begin r.n_re++;  if (r.re_at  < 0) r.re_at  = c; end
                if (mem_we)    begin r.n_we++;  if (r.we_at  < 0) r.we_at  = c; end
                if (err_proto) begin r.n_err++; if (r.err_at < 0) r.err_at = c; end
                if (use_if ? if_valid : d_valid) begin
                    r.v_at = c;
                    r.data = use_if ? if_rdata : d_rdata;
                    chk($sformatf("cfg%0d stall_at_valid", g), use_if ? stall_if : stall_mem, 1'b0);
                end else begin
                    chk($sformatf("cfg%0d stall_pending", g), use_if ? stall_if : stall_mem, 1'b1);
                end
                @(negedge clk);
            end
            if (use_if) if_req = 0;
            else begin d_req_rd = 0; d_req_wr = 0; end
            if (r.v_at < 0) chk($sformatf("cfg%0d completion_timeout", g), 32'(r.v_at), 32'(L + 2));
        endtask

        initial begin : stim
            res_t r;
            int   ord [10];
            int   k, rs;
            bit   seen;
            string p;
            p = $sformatf("cfg%0d ", g);
            rst = 1; if_req = 0; d_req_rd = 0; d_req_wr = 0;
            if_addr = '0; d_addr = '0; d_wdata = '0;
            repeat (2) @(negedge clk);
            rst = 0;

            // Fetch-only read of 0x10.
            run_req(1, 1, 0, 32'h10, 32'h0, r);
            chk({p, "fetch_re_cycle"},  32'(r.re_at), 32'd1);
            chk({p, "fetch_re_count"},  32'(r.n_re),  32'd1);
            chk({p, "fetch_we_count"},  32'(r.n_we),  32'd0);
            chk({p, "fetch_valid_cyc"}, 32'(r.v_at),  32'(2 + L));
            chk({p, "fetch_data"},      r.data,       32'h8C22_0004);

            // Store then load back the same word.
            run_req(0, 0, 1, 32'd5, 32'hDEAD_BEEF, r);
            chk({p, "wr_we_cycle"},   32'(r.we_at), 32'd1);
            chk({p, "wr_valid_cyc"},  32'(r.v_at),  32'd2);
            chk({p, "wr_re_count"},   32'(r.n_re),  32'd0);
            run_req(0, 1, 0, 32'd5, 32'h0, r);
            chk({p, "rd_valid_cyc"},  32'(r.v_at),  32'(2 + L));
            chk({p, "rd_re_count"},   32'(r.n_re),  32'd1);
            chk({p, "rd_data"},       r.data,       32'hDEAD_BEEF);

            // Both load and store strobes: handled as a flagged write.
            run_req(0, 1, 1, 32'd7, 32'h1234_5678, r);
            chk({p, "perr_err_cycle"}, 32'(r.err_at), 32'd1);
            chk({p, "perr_err_count"}, 32'(r.n_err),  32'd1);
            chk({p, "perr_we_cycle"},  32'(r.we_at),  32'd1);
            chk({p, "perr_re_count"},  32'(r.n_re),   32'd0);
            chk({p, "perr_valid_cyc"}, 32'(r.v_at),   32'd2);

            // Both requesters held: SM data completions, then one fetch, repeating.
            for (int i = 0; i < 10; i++) ord[i] = -1;
            if_req = 1; if_addr = 32'h20; d_req_rd = 1; d_req_wr = 0; d_addr = 32'd3;
            k = 0;
            for (int c = 0; c < 400 && k < 2 * (SM + 1); c++) begin
                #1;
                if (d_valid)  begin ord[k] = 0; k++; end
                if (if_valid) begin ord[k] = 1; k++; end
                @(negedge clk);
            end
            if_req = 0; d_req_rd = 0;
            chk({p, "starve_count"}, 32'(k), 32'(2 * (SM + 1)));
            for (int i = 0; i < 2 * (SM + 1); i++)
                chk($sformatf("%sstarve_order[%0d]", p, i), 32'(ord[i]),
                    (i % (SM + 1) == SM) ? 32'd1 : 32'd0);

            // Reset while the read is in WAIT: access dropped, outputs cleared.
            d_req_rd = 1; d_req_wr = 0; d_addr = 32'd9;
            seen = 0;
            for (int c = 0; c < 20 && !seen; c++) begin
                #1;
                seen = mem_re;
                @(negedge clk);
            end
            chk({p, "rstmid_issue_seen"}, 32'(seen), 32'd1);
            rst = 1;
            @(posedge clk);
            #1;
            chk({p, "rstmid_d_valid"},  32'(d_valid), 32'd0);
            chk({p, "rstmid_d_rdata"},  d_rdata,      32'h0);
            chk({p, "rstmid_if_rdata"}, if_rdata,     32'h0);
            chk({p, "rstmid_mem_addr"}, mem_addr,     32'h0);
            chk({p, "rstmid_strobes"},  {30'd0, mem_re, mem_we}, 32'h0);
            @(negedge clk);
            rst = 0;
            run_req(0, 1, 0, 32'd9, 32'h0, r);
            chk({p, "postrst_valid_cyc"}, 32'(r.v_at), 32'(2 + L));
            chk({p, "postrst_data"},      r.data,      seed(9));

            // Random traffic against the model.
            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                if (if_req && if_valid) if_req = 0;
                else if (!if_req && $urandom_range(3) == 0) begin
                    if_req = 1; if_addr = 32'($urandom_range(63));
                end
                if ((d_req_rd || d_req_wr) && d_valid) begin
                    d_req_rd = 0; d_req_wr = 0;
                end else if (!(d_req_rd || d_req_wr) && $urandom_range(2) == 0) begin
                    rs = int'($urandom_range(7));
                    d_req_rd = (rs < 4) || (rs == 7);
                    d_req_wr = (rs >= 4);
                    d_addr   = 32'($urandom_range(63));
                    d_wdata  = $urandom;
                end
                rst = ($urandom_range(299) == 0);
            end
            @(negedge clk);
            rst = 0; if_req = 0; d_req_rd = 0; d_req_wr = 0;
            repeat (12) @(negedge clk);
            done = 1;
        end
    end

    initial begin : summary
        int  cyc;
        bit  all_done;
        cyc = 0;
        all_done = 0;
        while (!all_done && cyc < 40000) begin
            @(posedge clk);
            cyc++;
            all_done = gi[0].done && gi[1].done;
        end
        chk("run_complete", 32'(all_done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
